// File: rtl/cam_pkg.sv
// cam_pkg: shared capture-path types and default frame geometry.
package cam_pkg;
  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} cam_state_e;
  typedef logic [15:0] rgb565_t;
endpackage

// File: rtl/dvp_byte_pair.sv
// dvp_byte_pair: pairs camera bytes (high byte first) into RGB565 pixels.
module dvp_byte_pair
  import cam_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clear_in,
  input  logic       take_in,
  input  logic [7:0] data_in,
  output logic       complete_out,
  output rgb565_t    pixel_out
);
  logic       phase_q;
  logic [7:0] high_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q <= 1'b0;
      high_q  <= '0;
    end else if (clear_in) begin
      phase_q <= 1'b0;
    end else if (take_in) begin
      phase_q <= ~phase_q;
      if (!phase_q) high_q <= data_in;
    end
  end
  assign complete_out = take_in && phase_q;
  assign pixel_out    = {high_q, data_in};
endmodule

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: turns a DVP byte stream into addressed RGB565 frame-buffer writes,
// tracking line/frame position and flagging over-long lines and aborted frames.
module frame_buffer_writer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  vsync_in,
  input  logic                  href_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            data_in,
  output rgb565_t               pixel_out,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  frame_done_out,
  output logic                  overrun_out
);
  localparam int HW = $clog2(H_ACTIVE + 1);
  localparam int VW = $clog2(V_ACTIVE + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FULL = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FULL = VW'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  cam_state_e            state_q, state_d;
  logic [HW-1:0]         hcount_q, hcount_d;
  logic [VW-1:0]         vcount_q, vcount_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  rgb565_t               pix_q, pix_d, pair_pix;
  logic                  wr_q, wr_d, done_q, done_d, ovr_q, ovr_d, href_q;
  logic                  live, take, line_end, clear, complete;

  assign live     = state_q == ACTIVE && !vsync_in;
  assign take     = live && href_in && byte_valid_in;
  assign line_end = live && href_q && !href_in && hcount_q != '0;

  dvp_byte_pair u_pair (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear_in     (clear),
    .take_in      (take),
    .data_in      (data_in),
    .complete_out (complete),
    .pixel_out    (pair_pix)
  );

  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    pix_d    = pix_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    clear    = line_end;
    case (state_q)
      IDLE: state_d = vsync_in ? SYNC : IDLE;
      SYNC: if (!vsync_in) begin
        state_d  = ACTIVE;
        clear    = 1'b1;
        hcount_d = '0;
        vcount_d = '0;
        addr_d   = '0;
      end
      ACTIVE: if (vsync_in) begin
        state_d = SYNC;
        ovr_d   = 1'b1;
      end else if (line_end) begin
        hcount_d = '0;
        // saturate so a runaway frame can never alias back onto the last line
        vcount_d = vcount_q == V_FULL ? vcount_q : vcount_q + 1'b1;
      end else if (complete && hcount_q >= H_FULL) begin
        ovr_d = 1'b1;
      end else if (complete) begin
        wr_d     = 1'b1;
        pix_d    = pair_pix;
        waddr_d  = addr_q;
        hcount_d = hcount_q + 1'b1;
        addr_d   = addr_q == A_LAST ? '0 : addr_q + 1'b1;
        done_d   = hcount_q == H_LAST && vcount_q == V_LAST;
        state_d  = done_d ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      hcount_q <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      pix_q    <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      href_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      waddr_q  <= waddr_d;
      pix_q    <= pix_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      href_q   <= href_in;
    end
  end

  assign pixel_out      = pix_q;
  assign wr_en_out      = wr_q;
  assign addr_out       = waddr_q;
  assign frame_done_out = done_q;
  assign overrun_out    = ovr_q;
endmodule
